// File: rtl/fabric_to_hps_packer.sv
// rtl/fabric_to_hps_packer.sv - packs fabric pixels into wide words for HPS readback over PIO
//
// Pixels are accumulated LSB-first into acc. A completed word moves into the
// hold register (in_data_export). If hold is still unread, the word stays
// parked in acc. The HPS acknowledges each read by flipping hps_ack_toggle.
//
// Ports:
//   clk_clk         fabric clock (HPS PIO shares this domain)
//   reset_reset     synchronous active-high reset
//   pix_valid/pix_data/pix_ready   pixel input handshake
//   hps_ack_toggle  HPS flips after reading in_data_export
//   in_data_export  packed word presented to the HPS
//   word_valid      in_data_export holds an unread word
//   word_seq        count of words loaded into hold (wraps)
//   ack_err         sticky: ack toggle seen with no word pending
//
// Optional build macro FABRIC_TO_HPS_PACKER_FLUSH_EN adds:
//   pix_last        completes the word early; unfilled upper slots stay zero
//   word_fill       number of valid pixels in in_data_export
module fabric_to_hps_packer #(
    parameter int DATA_W = 256,
    parameter int PIX_W  = 8,
    parameter int SEQ_W  = 8
) (
    input  logic                                clk_clk,
    input  logic                                reset_reset,
    input  logic                                pix_valid,
    input  logic [PIX_W-1:0]                    pix_data,
    output logic                                pix_ready,
`ifdef FABRIC_TO_HPS_PACKER_FLUSH_EN
    input  logic                                pix_last,
    output logic [$clog2(DATA_W/PIX_W):0]       word_fill,
`endif
    input  logic                                hps_ack_toggle,
    output logic [DATA_W-1:0]                   in_data_export,
    output logic                                word_valid,
    output logic [SEQ_W-1:0]                    word_seq,
    output logic                                ack_err
);

    localparam int N     = DATA_W / PIX_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  cnt;
    logic              acc_full;
    logic              hold_full;
    logic              ack_q;

    logic ack_evt;
    logic hold_free;
    logic accept;
    logic last_pix;
    logic complete;
    logic load_stored;
    logic load_direct;
    int   lsb;

    always_comb begin
        ack_evt   = hps_ack_toggle ^ ack_q;
        hold_free = !hold_full | ack_evt;
        pix_ready = !acc_full | hold_free;
        accept    = pix_valid & pix_ready;
`ifdef FABRIC_TO_HPS_PACKER_FLUSH_EN
        last_pix  = (cnt == CNT_W'(N - 1)) | pix_last;
`else
        last_pix  = (cnt == CNT_W'(N - 1));
`endif
        complete  = accept & last_pix;
        // A parked word always goes to hold before anything newer.
        load_stored = acc_full & hold_free;
        load_direct = complete & hold_free & !acc_full;

        // Slot 0 starts a fresh word from zero so early-completed words
        // carry zeros in their unused upper slots.
        lsb      = int'(cnt) * PIX_W;
        acc_next = (cnt == '0) ? '0 : acc;
        acc_next[lsb +: PIX_W] = pix_data;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            acc            <= '0;
            cnt            <= '0;
            acc_full       <= 1'b0;
            hold_full      <= 1'b0;
            in_data_export <= '0;
            word_seq       <= '0;
            ack_err        <= 1'b0;
            // Track the current level so a toggle held across reset is not an event.
            ack_q          <= hps_ack_toggle;
        end else begin
            ack_q <= hps_ack_toggle;

            if (ack_evt && !hold_full) begin
                ack_err <= 1'b1;
            end

            // A load in the same cycle as an ack retires the old word and
            // keeps hold_full set for the new one.
            if (load_stored) begin
                in_data_export <= acc;
                hold_full      <= 1'b1;
                word_seq       <= word_seq + 1'b1;
            end else if (load_direct) begin
                in_data_export <= acc_next;
                hold_full      <= 1'b1;
                word_seq       <= word_seq + 1'b1;
            end else if (ack_evt) begin
                hold_full <= 1'b0;
            end

            if (accept) begin
                acc <= acc_next;
                cnt <= complete ? '0 : cnt + 1'b1;
            end

            if (load_stored) begin
                acc_full <= 1'b0;
            end
            if (complete && !load_direct) begin
                acc_full <= 1'b1;
            end
        end
    end

    assign word_valid = hold_full;

`ifdef FABRIC_TO_HPS_PACKER_FLUSH_EN
    localparam int FILL_W = $clog2(N) + 1;

    logic [FILL_W-1:0] acc_fill;
    logic [FILL_W-1:0] hold_fill;
    logic [FILL_W-1:0] fill_next;

    assign fill_next = FILL_W'(cnt) + 1'b1;

    // Fill count travels with its word through acc and hold.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            acc_fill  <= '0;
            hold_fill <= '0;
        end else begin
            if (accept) begin
                acc_fill <= fill_next;
            end
            if (load_stored) begin
                hold_fill <= acc_fill;
            end else if (load_direct) begin
                hold_fill <= fill_next;
            end
        end
    end

    assign word_fill = hold_fill;
`endif

endmodule
